// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command transmitter
//
// Sends one command byte from the host to a PS/2 device using the
// sequence inhibit, request-to-send, then device-clocked data, parity
// and stop bits, then the device ACK.
//
// Ports:
//   clk, rst_n          system clock; asynchronous active-low reset
//   tx_valid, tx_data   request to send one byte; accepted when tx_ready=1
//   tx_ready, busy      idle / frame in progress (busy = ~tx_ready)
//   done                one-cycle pulse when the frame ends and the bus is idle
//   ack_err             pulses together with done if the device did not ACK
//   timeout_err         one-cycle pulse when the watchdog expires (no done)
//   ps2_clk_in          raw PS/2 clock line (asynchronous)
//   ps2_data_in         raw PS/2 data line (asynchronous)
//   ps2_clk_oe          1 = pull the PS/2 clock line low
//   ps2_data_oe         1 = pull the PS/2 data line low
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_PHASE = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_PARAM = (MAX_PHASE > TIMEOUT_CYCLES) ? MAX_PHASE : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(MAX_PARAM) + 1;

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST     = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] WD_LIMIT     = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   phase_cnt, phase_cnt_nx;
  logic [CW-1:0]   wd_cnt, wd_cnt_nx;
  logic [3:0]      edge_cnt, edge_cnt_nx;
  logic [7:0]      shift, shift_nx;
  logic            parity, parity_nx;
  logic            ack_bad, ack_bad_nx;
  logic            clk_oe_q, clk_oe_nx;
  logic            data_oe_q, data_oe_nx;
  logic            done_c, ack_err_c, timeout_c;

  // Two-stage synchronizers; the extra clk_prev stage gives the edge detector
  // a clean previous value. Bus idles high, so all stages reset to 1.
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      wd_cnt    <= '0;
      edge_cnt  <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      ack_bad   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_cnt_nx;
      wd_cnt    <= wd_cnt_nx;
      edge_cnt  <= edge_cnt_nx;
      shift     <= shift_nx;
      parity    <= parity_nx;
      ack_bad   <= ack_bad_nx;
      clk_oe_q  <= clk_oe_nx;
      data_oe_q <= data_oe_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    phase_cnt_nx = phase_cnt;
    wd_cnt_nx    = wd_cnt;
    edge_cnt_nx  = edge_cnt;
    shift_nx     = shift;
    parity_nx    = parity;
    ack_bad_nx   = ack_bad;
    clk_oe_nx    = clk_oe_q;
    data_oe_nx   = data_oe_q;
    done_c       = 1'b0;
    ack_err_c    = 1'b0;
    timeout_c    = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shift_nx     = tx_data;
          parity_nx    = ~^tx_data;
          edge_cnt_nx  = '0;
          phase_cnt_nx = '0;
          ack_bad_nx   = 1'b0;
          clk_oe_nx    = 1'b1;
          data_oe_nx   = 1'b0;
          state_nx     = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (phase_cnt == INHIBIT_LAST) begin
          phase_cnt_nx = '0;
          data_oe_nx   = 1'b1;        // start bit
          state_nx     = S_RTS;
        end else begin
          phase_cnt_nx = phase_cnt + 1'b1;
        end
      end

      S_RTS: begin
        if (phase_cnt == RTS_LAST) begin
          clk_oe_nx = 1'b0;           // hand the clock to the device
          wd_cnt_nx = '0;
          state_nx  = S_DATA;
        end else begin
          phase_cnt_nx = phase_cnt + 1'b1;
        end
      end

      S_DATA, S_ACK, S_WAIT_IDLE: begin
        wd_cnt_nx = wd_cnt + 1'b1;
        // The watchdog wins over any bus event in the same cycle.
        if (wd_cnt == WD_LIMIT) begin
          timeout_c  = 1'b1;
          clk_oe_nx  = 1'b0;
          data_oe_nx = 1'b0;
          state_nx   = S_IDLE;
        end else if (state == S_DATA) begin
          if (fall) begin
            edge_cnt_nx = edge_cnt + 1'b1;
            if (edge_cnt < 4'd8) begin
              data_oe_nx = ~shift[0];
              shift_nx   = {1'b0, shift[7:1]};
            end else if (edge_cnt == 4'd8) begin
              data_oe_nx = ~parity;
            end else begin
              data_oe_nx = 1'b0;      // stop bit: release data
              state_nx   = S_ACK;
            end
          end
        end else if (state == S_ACK) begin
          if (fall) begin
            edge_cnt_nx = edge_cnt + 1'b1;
            ack_bad_nx  = data_s2;
            state_nx    = S_WAIT_IDLE;
          end
        end else begin
          if (clk_s2 && data_s2) begin
            done_c    = 1'b1;
            ack_err_c = ack_bad;
            state_nx  = S_IDLE;
          end
        end
      end

      default: begin
        clk_oe_nx  = 1'b0;
        data_oe_nx = 1'b0;
        state_nx   = S_IDLE;
      end
    endcase
  end

  assign tx_ready    = (state == S_IDLE);
  assign busy        = ~tx_ready;
  assign done        = done_c;
  assign ack_err     = ack_err_c;
  assign timeout_err = timeout_c;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - scoreboard bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;
  localparam int INH  = 20;
  localparam int RTS  = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, ack_err, timeout_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       clk_line, data_line;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout_err(timeout_err),
    .ps2_clk_in(clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // kind: 0 = ACKed, 1 = no ACK, 2 = device silent (timeout)
  typedef struct {
    logic [7:0] data;
    int         kind;
  } exp_t;
  exp_t exp_q[$];

  int         dev_mode = 0;
  logic       dev_abort = 1'b0;
  logic       dev_busy = 1'b0;
  int         dev_fall_cnt = 0;
  int         dev_acks = 0;
  logic [7:0] dev_byte = 8'h00;
  logic       dev_par = 1'b0;
  logic       dev_stop = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Device model: on request-to-send, clocks 11 pulses, samples the host's
  // bits at the end of each low phase and optionally ACKs on pulse 11.
  initial begin
    forever begin
      @(negedge ps2_clk_oe);
      #1;
      if (ps2_data_oe && dev_mode != 2) begin
        dev_busy = 1'b1;
        dev_fall_cnt = 0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        for (int i = 1; i <= 11 && !dev_abort; i++) begin
          if (i == 11 && dev_mode == 0) begin
            dev_data_low = 1'b1;
            dev_acks++;
          end
          dev_clk_low = 1'b1;
          dev_fall_cnt = i;
          for (int k = 0; k < HALF && !dev_abort; k++) @(negedge clk);
          if (i <= 8) dev_byte[i-1] = data_line;
          else if (i == 9) dev_par = data_line;
          else if (i == 10) dev_stop = data_line;
          dev_clk_low = 1'b0;
          for (int k = 0; k < HALF && !dev_abort; k++) @(negedge clk);
        end
        dev_data_low = 1'b0;
        dev_clk_low = 1'b0;
        dev_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT ends a frame.
  initial begin
    int   cyc, run, last_run, rel_cyc;
    bit   after_done, after_tmo;
    exp_t e;
    int   exp_par;
    cyc = 0; run = 0; last_run = 0; rel_cyc = 0;
    after_done = 0; after_tmo = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (after_done) begin
        check("done_single_pulse", done, 0);
        check("ready_after_done", tx_ready, 1);
        after_done = 0;
      end
      if (after_tmo) begin
        check("tmo_clk_oe_released", ps2_clk_oe, 0);
        check("tmo_data_oe_released", ps2_data_oe, 0);
        check("tmo_ready", tx_ready, 1);
        after_tmo = 0;
      end
      if (ps2_clk_oe) run++;
      else if (run > 0) begin
        last_run = run;
        rel_cyc = cyc;
        run = 0;
      end
      if (rst_n && (done || timeout_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_end: done=%0d timeout_err=%0d with empty scoreboard", done, timeout_err);
        end else begin
          e = exp_q.pop_front();
          check("end_kind", timeout_err ? 2 : (ack_err ? 1 : 0), e.kind);
          if (e.kind == 2) begin
            check("timeout_latency", cyc - rel_cyc, TMO);
            check("no_done_on_timeout", done, 0);
            after_tmo = 1;
          end else begin
            exp_par = (($countones(e.data) % 2) == 0) ? 1 : 0;
            check("line_byte", dev_byte, e.data);
            check("line_parity", dev_par, exp_par);
            check("line_stop", dev_stop, 1);
            check("clk_oe_low_cycles", last_run, INH + RTS);
            check("ready_low_at_done", tx_ready, 0);
            after_done = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int mode, input bit hold);
    exp_t e;
    int   n;
    dev_mode = mode;
    e.data = b;
    e.kind = mode;
    exp_q.push_back(e);
    n = 0;
    while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (hold) tx_data = 8'h55;
    else tx_valid = 1'b0;
    n = 0;
    while (!(done || timeout_err) && n < 5000) begin @(negedge clk); n++; end
    tx_valid = 1'b0;
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL frame_end_wait: no done/timeout_err within 5000 cycles for 0x%0h", b);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n, acks_before;
    logic [7:0] rb;
    int rm;

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hED, 0, 0);
    send(8'hF4, 1, 0);
    send(8'h00, 2, 0);
    send(8'h01, 0, 0);
    send(8'hED, 0, 1);
    send(8'h55, 0, 0);

    // Reset during inhibit: clock pull-down must drop without a clock edge.
    dev_mode = 0;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("inhibit_clk_oe", ps2_clk_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_clk_oe", ps2_clk_oe, 0);
    check("rst_async_ready_inh", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during data bit 4.
    acks_before = dev_acks;
    dev_mode = 0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (dev_fall_cnt < 4 && n < 5000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("midframe_data_oe", ps2_data_oe, 1);
    dev_abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_async_data_oe", ps2_data_oe, 0);
    check("rst_async_clk_oe2", ps2_clk_oe, 0);
    check("rst_async_ready", tx_ready, 1);
    n = 0;
    while (dev_busy && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dev_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("ready_after_reset", tx_ready, 1);
    check("partial_not_acked", dev_acks, acks_before);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      rm = $urandom_range(0, 3);
      if (rm == 3) rm = 0;
      send(rb, rm, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
